// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch unit: the request/address go out,
// the ready strobe and read data come back.
`timescale 1ns/1ps
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/EXEC/FAULT sequencer that latches one word per
// instruction from instruction memory and commits the controller's next-PC choice.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic [1:0]         pc_src,
    input  logic [31:0]        rs_data,
    input  logic               advance,
    output logic               fault
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] inst_next;
    logic [7:0]  tmo_cnt;
    logic [7:0]  tmo_cnt_next;
    logic [31:0] branch_off;
    logic [31:0] target;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{inst[15]}}, inst[15:0], 2'b00};

    always_comb begin
        target = pc_plus4;
        unique case (pc_src)
            2'b00:   target = pc_plus4;
            2'b01:   target = pc_plus4 + branch_off;
            2'b10:   target = rs_data;
            default: target = {pc_plus4[31:28], inst[25:0], 2'b00};
        endcase
    end

    // Misaligned targets leave pc untouched and park the unit in FAULT until reset.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        inst_next    = inst;
        tmo_cnt_next = tmo_cnt;
        unique case (state)
            FETCH: begin
                if (imem.ready) begin
                    inst_next    = imem.rdata;
                    tmo_cnt_next = 8'd0;
                    state_next   = EXEC;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'd1;
                    if (tmo_cnt == TMO_LAST) begin
                        state_next = FAULT;
                    end
                end
            end
            EXEC: begin
                if (advance) begin
                    if (target[1:0] == 2'b00) begin
                        pc_next    = target;
                        state_next = FETCH;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            inst    <= 32'h0000_0000;
            tmo_cnt <= 8'd0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            inst    <= inst_next;
            tmo_cnt <= tmo_cnt_next;
        end
    end

    assign imem.req   = (state == FETCH);
    assign imem.addr  = pc;
    assign inst_valid = (state == EXEC);
    assign fault      = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// instruction stream checked against a transaction-level next-PC model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC      = 32'h0000_0000;
    localparam int          FETCH_TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_src;
    logic [31:0] rs_data;
    logic        advance;
    logic        fault;

    int vectors;
    int miscompares;

    fetch_unit_if imem();

    fetch_unit #(
        .RESET_PC      (RESET_PC),
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (imem),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .pc_src     (pc_src),
        .rs_data    (rs_data),
        .advance    (advance),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Next-PC rule from the instruction-set view: plain integer arithmetic on the word.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [31:0] word,
                                                input logic [1:0] src, input logic [31:0] rs);
        logic [31:0] r;
        case (src)
            2'd0:    r = cur_pc + 32'd4;
            2'd1:    r = cur_pc + 32'd4 + 32'(4 * int'($signed(word[15:0])));
            2'd2:    r = rs;
            default: r = ((cur_pc + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        imem.ready = 1'b0;
        imem.rdata = 32'h0;
        advance    = 1'b0;
        pc_src     = 2'b00;
        rs_data    = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic capture(input logic [31:0] word);
        imem.ready = 1'b1;
        imem.rdata = word;
        tick();
        imem.ready = 1'b0;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        capture(32'h0);
        pc_src  = 2'b10;
        rs_data = addr;
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pc !== RESET_PC) begin
            miscompares++;
            $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC);
        end
        vectors++;
        if (inst !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_inst: got %h expected %h", inst, 32'h0);
        end
        vectors++;
        if ({imem.req, inst_valid, fault} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_flags req/valid/fault: got %b expected %b",
                     {imem.req, inst_valid, fault}, 3'b100);
        end
        vectors++;
        if (pc_plus4 !== RESET_PC + 32'd4) begin
            miscompares++;
            $display("[TB] FAIL reset_pc_plus4: got %h expected %h", pc_plus4, RESET_PC + 32'd4);
        end
        apply_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] word;
        apply_reset();
        imem.ready = 1'b1;
        advance    = 1'b1;
        pc_src     = 2'b00;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (imem.addr !== RESET_PC + 32'(4 * i) || inst_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL seq_fetch[%0d] addr/valid: got %h/%b expected %h/0",
                         i, imem.addr, inst_valid, RESET_PC + 32'(4 * i));
            end
            word       = $urandom;
            imem.rdata = word;
            tick();
            vectors++;
            if (inst_valid !== 1'b1 || inst !== word) begin
                miscompares++;
                $display("[TB] FAIL seq_exec[%0d] valid/inst: got %b/%h expected 1/%h",
                         i, inst_valid, inst, word);
            end
            tick();
        end
        imem.ready = 1'b0;
        advance    = 1'b0;
    endtask

    task automatic test_branch();
        logic [15:0] offs [2];
        logic [31:0] exp  [2];
        offs[0] = 16'hFFFE; exp[0] = 32'h0000_00FC;
        offs[1] = 16'h0003; exp[1] = 32'h0000_0110;
        for (int i = 0; i < 2; i++) begin
            apply_reset();
            goto_pc(32'h0000_0100);
            capture({16'h1000, offs[i]});
            pc_src  = 2'b01;
            advance = 1'b1;
            tick();
            advance = 1'b0;
            vectors++;
            if (imem.addr !== exp[i] || imem.req !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL branch[%0d] addr/req: got %h/%b expected %h/1",
                         i, imem.addr, imem.req, exp[i]);
            end
        end
    endtask

    task automatic test_jump();
        apply_reset();
        goto_pc(32'h9000_0010);
        capture(32'h0800_0040);
        pc_src  = 2'b11;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        vectors++;
        if (pc !== 32'h9000_0100) begin
            miscompares++;
            $display("[TB] FAIL jump pc: got %h expected %h", pc, 32'h9000_0100);
        end
        capture($urandom);
        pc_src  = 2'b10;
        rs_data = 32'h0000_2000;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        vectors++;
        if (pc !== 32'h0000_2000) begin
            miscompares++;
            $display("[TB] FAIL jr pc: got %h expected %h", pc, 32'h0000_2000);
        end
    endtask

    task automatic test_misaligned_jr();
        capture($urandom);
        pc_src  = 2'b10;
        rs_data = 32'h0000_2002;
        advance = 1'b1;
        tick();
        vectors++;
        if ({fault, imem.req, inst_valid} !== 3'b100 || pc !== 32'h0000_2000) begin
            miscompares++;
            $display("[TB] FAIL misaligned_jr fault/req/valid pc: got %b %h expected 100 %h",
                     {fault, imem.req, inst_valid}, pc, 32'h0000_2000);
        end
        for (int i = 0; i < 4; i++) begin
            imem.ready = 1'b1;
            imem.rdata = $urandom;
            advance    = 1'b1;
            pc_src     = 2'($urandom_range(0, 3));
            rs_data    = $urandom & 32'hFFFF_FFFC;
            tick();
            vectors++;
            if (fault !== 1'b1 || pc !== 32'h0000_2000 || imem.req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL fault_sticky[%0d] fault/req pc: got %b/%b %h expected 1/0 %h",
                         i, fault, imem.req, pc, 32'h0000_2000);
            end
        end
        apply_reset();
        vectors++;
        if (fault !== 1'b0 || pc !== RESET_PC) begin
            miscompares++;
            $display("[TB] FAIL fault_exit fault pc: got %b %h expected 0 %h", fault, pc, RESET_PC);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] word;
        apply_reset();
        imem.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (inst_valid !== 1'b0 || imem.req !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL wait[%0d] valid/req: got %b/%b expected 0/1", i, inst_valid, imem.req);
            end
        end
        word = $urandom;
        capture(word);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== word) begin
            miscompares++;
            $display("[TB] FAIL wait_capture valid/inst: got %b/%h expected 1/%h", inst_valid, inst, word);
        end
        imem.ready = 1'b1;
        imem.rdata = ~word;
        tick();
        imem.ready = 1'b0;
        vectors++;
        if (inst !== word) begin
            miscompares++;
            $display("[TB] FAIL ready_ignored_in_exec inst: got %h expected %h", inst, word);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        imem.ready = 1'b0;
        for (int i = 1; i <= FETCH_TIMEOUT; i++) begin
            tick();
            vectors++;
            if (fault !== (i == FETCH_TIMEOUT)) begin
                miscompares++;
                $display("[TB] FAIL timeout cycle %0d fault: got %b expected %b",
                         i, fault, (i == FETCH_TIMEOUT));
            end
        end
        apply_reset();
    endtask

    task automatic test_async_reset();
        goto_pc(32'h0000_0040);
        capture(32'hDEAD_BEEF);
        #3;
        rst_n      = 1'b0;
        imem.ready = 1'b1;
        imem.rdata = 32'h1234_5678;
        #1;
        vectors++;
        if (pc !== RESET_PC || inst_valid !== 1'b0 || inst !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset pc/valid/inst: got %h/%b/%h expected %h/0/0",
                     pc, inst_valid, inst, RESET_PC);
        end
        tick();
        vectors++;
        if (inst !== 32'h0 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL late_ready_captured inst/valid: got %h/%b expected 0/0", inst, inst_valid);
        end
        apply_reset();
    endtask

    task automatic test_stall();
        logic [31:0] word;
        logic [31:0] held_pc;
        goto_pc(32'h0000_0800);
        word = $urandom;
        capture(word);
        held_pc = pc;
        advance = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_src     = 2'($urandom_range(0, 3));
            rs_data    = $urandom;
            imem.ready = 1'($urandom_range(0, 1));
            imem.rdata = $urandom;
            tick();
            vectors++;
            if (pc !== 32'h0000_0800 || inst !== word || imem.req !== 1'b0 || inst_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stall[%0d] pc/inst/req/valid: got %h/%h/%b/%b expected %h/%h/0/1",
                         i, pc, inst, imem.req, inst_valid, held_pc, word);
            end
        end
        imem.ready = 1'b0;
        apply_reset();
    endtask

    task automatic test_random_stream();
        logic [31:0] model_pc;
        logic [31:0] word;
        logic [31:0] exp_pc;
        logic [1:0]  src;
        int          waits;
        int          stalls;
        apply_reset();
        model_pc = RESET_PC;
        for (int n = 0; n < 60; n++) begin
            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                advance    = 1'($urandom_range(0, 1));
                imem.ready = 1'b0;
                tick();
            end
            vectors++;
            if (imem.addr !== model_pc || imem.req !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rand[%0d] fetch addr/req: got %h/%b expected %h/1",
                         n, imem.addr, imem.req, model_pc);
            end
            advance = 1'b0;
            word    = $urandom;
            capture(word);
            stalls = $urandom_range(0, 2);
            for (int s = 0; s < stalls; s++) begin
                pc_src  = 2'($urandom_range(0, 3));
                rs_data = $urandom;
                tick();
            end
            vectors++;
            if (inst !== word || inst_valid !== 1'b1 || pc !== model_pc) begin
                miscompares++;
                $display("[TB] FAIL rand[%0d] exec inst/valid/pc: got %h/%b/%h expected %h/1/%h",
                         n, inst, inst_valid, pc, word, model_pc);
            end
            src     = 2'($urandom_range(0, 3));
            rs_data = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            pc_src  = src;
            advance = 1'b1;
            exp_pc  = ref_next_pc(model_pc, word, src, rs_data);
            tick();
            advance = 1'b0;
            if (exp_pc % 4 != 0) begin
                vectors++;
                if (fault !== 1'b1 || pc !== model_pc || imem.req !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rand[%0d] misaligned fault/req pc: got %b/%b %h expected 1/0 %h",
                             n, fault, imem.req, pc, model_pc);
                end
                apply_reset();
                model_pc = RESET_PC;
            end else begin
                model_pc = exp_pc;
                vectors++;
                if (pc !== model_pc || fault !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rand[%0d] next pc/fault: got %h/%b expected %h/0",
                             n, pc, fault, model_pc);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        imem.ready  = 1'b0;
        imem.rdata  = 32'h0;
        advance     = 1'b0;
        pc_src      = 2'b00;
        rs_data     = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_misaligned_jr();
        test_wait_states();
        test_timeout();
        test_async_reset();
        test_stall();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
